// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One right-shifting Galois step for x^16+x^14+x^13+x^11+1
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/f1_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clk and never reaches zero from a non-zero seed.
module f1_lfsr16
  import f1_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= lfsr_step(q);
  end

endmodule

// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: fills lamps one per tick, holds for a (pseudo-random) time,
// then extinguishes them and pulses lights_out as the reaction-timer reference.
module f1_start_seq
  import f1_pkg::*;
#(
  parameter int unsigned N_LIGHTS  = 8,
  parameter int unsigned HOLD_MIN  = 2,
  parameter int unsigned RAND_EN   = 1,
  parameter int unsigned RAND_W    = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                trigger,
  input  logic                auto_mode,
  input  logic                abort,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                lights_out
);

  localparam int unsigned CNT_W = $clog2(HOLD_MIN + 2**RAND_W + 1);

  seq_state_t          state_q, state_d;
  logic [N_LIGHTS-1:0] data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    hold_load;
  logic                lights_out_d;
  logic                busy_d;
  logic [15:0]         lfsr_q;

  f1_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Hold count sampled from the LFSR on the tick that lights the last lamp
  always_comb begin
    hold_load = CNT_W'(HOLD_MIN);
    if (RAND_EN != 0) hold_load = CNT_W'(HOLD_MIN) + CNT_W'(lfsr_q[RAND_W-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_out   <= '0;
      cnt_q      <= '0;
      lights_out <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out   <= data_d;
      cnt_q      <= cnt_d;
      lights_out <= lights_out_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_out;
    cnt_d        = cnt_q;
    lights_out_d = 1'b0;

    if (abort) begin
      state_d = IDLE;
      data_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          data_d = '0;
          if (trigger || auto_mode) state_d = FILL;
        end
        FILL: begin
          if (en) begin
            data_d = {data_out[N_LIGHTS-2:0], 1'b1};
            if (&data_out[N_LIGHTS-2:0]) begin
              state_d = HOLD;
              cnt_d   = hold_load;
            end
          end
        end
        HOLD: begin
          if (en) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              data_d       = '0;
              lights_out_d = 1'b1;
              state_d      = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

endmodule
